// File: rtl/store_unit_pkg.sv
// Package for the LEGv8 store unit.
// Holds the store opcode patterns, the bus geometry, the FSM state type and two
// helpers: opcode -> store size in bytes, and the beat search over a 12-bit
// lane mask (three 4-byte beats).
package store_unit_pkg;

    localparam int INSTR_LEN = 32;
    localparam int WORD      = 64;
    localparam int BUS_W     = 32;
    localparam int BUS_BYTES = 4;

    // Opcode field instruction[31:21]
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_STURW = 11'b10111000000;
    localparam logic [10:0] OP_STURH = 11'b01111000000;
    localparam logic [10:0] OP_STURB = 11'b00111000000;

    typedef enum logic [1:0] {
        SU_IDLE,
        SU_SEND,
        SU_DONE
    } su_state_t;

    // Store size in bytes; 0 means the opcode is not a store.
    function automatic logic [3:0] store_size(input logic [10:0] op);
        logic [3:0] size;
        size = 4'd0;
        casez (op)
            OP_STUR:  size = 4'd8;
            OP_STURW: size = 4'd4;
            OP_STURH: size = 4'd2;
            OP_STURB: size = 4'd1;
            default:  size = 4'd0;
        endcase
        return size;
    endfunction

    // Lowest beat index >= from whose 4-bit mask is nonzero.
    // Result is {found, index}.
    function automatic logic [2:0] find_beat(input logic [11:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (res[2] == 1'b0 && k >= 32'(from) && mask[4*k +: 4] != 4'b0000) begin
                res = {1'b1, 2'(k)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Byte-enabled 32-bit write bus between the store unit (master) and data
// memory (slave). A beat transfers on a cycle where bus_valid & bus_ready.
//   bus_valid  master->slave  beat request
//   bus_ready  slave->master  memory accepts the beat
//   bus_addr   master->slave  word-aligned byte address
//   bus_wdata  master->slave  lane-aligned write data
//   bus_be     master->slave  byte enables, bit i covers bus_wdata[8i+:8]
interface store_unit_if #(
    parameter int ADDR_W = 64
) ();
    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_be;

    modport master (
        output bus_valid,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_ready
    );

    modport slave (
        input  bus_valid,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_ready
    );
endinterface

// File: rtl/store_unit_lane_aligner.sv
// store_lane_aligner: combinational placement of a 1/2/4/8-byte store onto
// three consecutive 32-bit bus words.
//   i_size    store size in bytes (1,2,4,8)
//   i_off     byte offset within the first word (address[1:0])
//   i_data    register value; bytes above i_size are discarded
//   o_data96  data shifted to its lanes, word k in [32k+:32]
//   o_mask12  byte enables, word k in [4k+:4]
module store_lane_aligner
    import store_unit_pkg::*;
(
    input  logic [3:0]      i_size,
    input  logic [1:0]      i_off,
    input  logic [WORD-1:0] i_data,
    output logic [95:0]     o_data96,
    output logic [11:0]     o_mask12
);

    logic [WORD-1:0] w_trunc;
    logic [11:0]     w_size_mask;

    always_comb begin
        w_trunc = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b < 32'(i_size)) begin
                w_trunc[8*b +: 8] = i_data[8*b +: 8];
            end
        end
        w_size_mask = (12'd1 << i_size) - 12'd1;
        o_mask12    = w_size_mask << i_off;
        o_data96    = {32'b0, w_trunc} << {i_off, 3'b000};
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: store side of the LEGv8 data memory interface.
// Decodes STUR/STURW/STURH/STURB, aligns the register value onto the 32-bit
// byte-enabled bus and issues 1-3 beats, stalling the core until retirement.
//   clk, reset    clock; synchronous active-high reset
//   start         core request for the current instruction
//   instruction   opcode taken from [31:21]
//   address       effective byte address
//   store_data    Rt value
//   stall         hold PC/instruction while high
//   done          one-cycle pulse when the store retires
//   bus           master side of store_unit_if
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_W = WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic [ADDR_W-1:0]    address,
    input  logic [WORD-1:0]      store_data,
    output logic                 stall,
    output logic                 done,
    store_unit_if.master         bus
);

    su_state_t         r_state;
    su_state_t         w_state_next;
    logic [1:0]        r_beat;
    logic [1:0]        w_beat_next;
    logic              w_load;
    logic [95:0]       r_data96;
    logic [11:0]       r_mask12;
    logic [ADDR_W-1:0] r_word_addr;

    logic [3:0]        w_size;
    logic              w_is_store;
    logic [95:0]       w_data96;
    logic [11:0]       w_mask12;
    logic [2:0]        w_first;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] w_beat_addr;

    // Operand bits with no role in a store.
    logic              w_unused_bits;
    assign w_unused_bits = ^{instruction[20:0], w_first[2]};

    assign w_size     = store_size(instruction[31:21]);
    assign w_is_store = (w_size != 4'd0);

    store_lane_aligner u_aligner (
        .i_size   (w_size),
        .i_off    (address[1:0]),
        .i_data   (store_data),
        .o_data96 (w_data96),
        .o_mask12 (w_mask12)
    );

    // The aligned image is latched instead of the raw operands, so later
    // input changes cannot disturb the beats in flight.
    assign w_first     = find_beat(w_mask12, 3'd0);
    assign w_next      = find_beat(r_mask12, {1'b0, r_beat} + 3'd1);
    assign w_beat_addr = r_word_addr + ADDR_W'({r_beat, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SU_IDLE;
            r_beat      <= '0;
            r_data96    <= '0;
            r_mask12    <= '0;
            r_word_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
            if (w_load) begin
                r_data96    <= w_data96;
                r_mask12    <= w_mask12;
                r_word_addr <= {address[ADDR_W-1:2], 2'b00};
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_beat_next   = r_beat;
        w_load        = 1'b0;
        stall         = 1'b0;
        done          = 1'b0;
        bus.bus_valid = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_be    = '0;

        case (r_state)
            SU_IDLE: begin
                if (start && w_is_store) begin
                    stall        = 1'b1;
                    w_load       = 1'b1;
                    w_beat_next  = w_first[1:0];
                    w_state_next = SU_SEND;
                end
            end
            SU_SEND: begin
                stall         = 1'b1;
                bus.bus_valid = 1'b1;
                bus.bus_addr  = w_beat_addr;
                bus.bus_wdata = r_data96[{r_beat, 5'b00000} +: 32];
                bus.bus_be    = r_mask12[{r_beat, 2'b00} +: 4];
                if (bus.bus_ready) begin
                    if (w_next[2]) begin
                        w_beat_next = w_next[1:0];
                    end else begin
                        w_state_next = SU_DONE;
                    end
                end
            end
            SU_DONE: begin
                done         = 1'b1;
                w_state_next = SU_IDLE;
            end
            default: begin
                w_state_next = SU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

    localparam int ADDR_W = 64;

    localparam logic [10:0] T_STUR  = 11'b11111000000;
    localparam logic [10:0] T_STURW = 11'b10111000000;
    localparam logic [10:0] T_STURH = 11'b01111000000;
    localparam logic [10:0] T_STURB = 11'b00111000000;
    localparam logic [10:0] T_ADD   = 11'b10001011000;
    localparam logic [10:0] T_LDUR  = 11'b11111000010;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic [63:0] address;
    logic [63:0] store_data;
    logic        stall;
    logic        done;

    store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .address     (address),
        .store_data  (store_data),
        .stall       (stall),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    mode    = 0;   // 0: ready high, 1: random ready, 2: 5 low cycles per beat
    int    wait_cnt = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [63:0] a, input logic [31:0] d, input logic [3:0] be);
        beat_t b;
        b.addr = a; b.wdata = d; b.be = be;
        sb.push_back(b);
    endtask

    function automatic int size_of(input logic [10:0] op);
        case (op)
            T_STUR:  return 8;
            T_STURW: return 4;
            T_STURH: return 2;
            T_STURB: return 1;
            default: return 0;
        endcase
    endfunction

    // Byte-by-byte reference: byte j of the register goes to address addr+j;
    // consecutive bytes sharing a word form one beat.
    task automatic model_push(input int size, input logic [63:0] addr, input logic [63:0] data,
                              output int nbeats);
        logic [63:0] a, w, wa;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          have;
        have = 0; nbeats = 0; wa = '0; wd = '0; be = '0;
        for (int j = 0; j < size; j++) begin
            a = addr + 64'(j);
            w = {a[63:2], 2'b00};
            if (have && w != wa) begin
                push_beat(wa, wd, be); nbeats++;
                wd = '0; be = '0;
            end
            wd[8*a[1:0] +: 8] = data[8*j +: 8];
            be[a[1:0]] = 1'b1;
            wa = w; have = 1;
        end
        if (have) begin
            push_beat(wa, wd, be); nbeats++;
        end
    endtask

    function automatic logic [10:0] rand_op();
        case ($urandom_range(0, 5))
            0: return T_STUR;
            1: return T_STURW;
            2: return T_STURH;
            3: return T_STURB;
            4: return T_ADD;
            default: return T_LDUR;
        endcase
    endfunction

    // Bus ready generator
    initial begin
        bit hs;
        bus.bus_ready = 1'b0;
        forever begin
            @(negedge clk);
            hs = bus.bus_valid && bus.bus_ready && !reset;
            @(posedge clk);
            #1;
            if (hs) wait_cnt = 0;
            case (mode)
                0: bus.bus_ready = 1'b1;
                1: bus.bus_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.bus_valid) begin
                        if (wait_cnt < 5) begin
                            bus.bus_ready = 1'b0;
                            wait_cnt++;
                        end else begin
                            bus.bus_ready = 1'b1;
                        end
                    end else begin
                        bus.bus_ready = 1'($urandom_range(0, 1));
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake
    initial begin
        beat_t       e;
        logic        p_wait;
        logic [63:0] p_addr;
        logic [31:0] p_wdata;
        logic [3:0]  p_be;
        p_wait = 1'b0; p_addr = '0; p_wdata = '0; p_be = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.bus_valid && p_wait) begin
                check("hold_addr", bus.bus_addr, p_addr);
                check("hold_wdata", bus.bus_wdata, p_wdata);
                check("hold_be", bus.bus_be, p_be);
            end
            if (!reset && bus.bus_valid && bus.bus_ready) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_beat: got addr 0x%0h with no beat expected", bus.bus_addr);
                end else begin
                    e = sb.pop_front();
                    check("beat_addr", bus.bus_addr, e.addr);
                    check("beat_wdata", bus.bus_wdata, e.wdata);
                    check("beat_be", bus.bus_be, e.be);
                end
            end
            if (!reset && done) check("done_all_beats_retired", sb.size(), 0);
            p_wait  = !reset && bus.bus_valid && !bus.bus_ready;
            p_addr  = bus.bus_addr;
            p_wdata = bus.bus_wdata;
            p_be    = bus.bus_be;
        end
    end

    // Issue one store and follow it to retirement; start stays high throughout
    // (including DONE) while the other inputs are scrambled.
    task automatic run_store(input logic [10:0] op, input logic [63:0] addr,
                             input logic [63:0] data, input int nbeats);
        int stall_cnt;
        bit got_done;
        stall_cnt = 0; got_done = 0;
        @(posedge clk); #1;
        instruction = {op, 21'($urandom)};
        address     = addr;
        store_data  = data;
        start       = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                check("done_stall_low", {bus.bus_valid, stall}, 2'b00);
                break;
            end
            check("stall_high", stall, 1'b1);
            stall_cnt++;
            @(posedge clk); #1;
            instruction = {rand_op(), 21'($urandom)};
            address     = {$urandom, $urandom};
            store_data  = {$urandom, $urandom};
        end
        if (!got_done) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done within 300 cycles, required one");
        end
        if (mode == 0) check("stall_cycles", stall_cnt, nbeats + 1);
        else           check("stall_cycles_min", (stall_cnt >= nbeats + 1), 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("post_done_quiet", {done, stall, bus.bus_valid}, 3'b000);
    endtask

    initial begin
        int nb;
        logic [10:0] op;
        logic [63:0] a, d;

        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        logic [10:0] op;
        logic [63:0] a, d;

        reset = 1'b1; start = 1'b0; instruction = '0; address = '0; store_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {stall, done, bus.bus_valid, bus.bus_be, bus.bus_addr, bus.bus_wdata},
              '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: single byte at top lane
        mode = 0;
        push_beat(64'h1000, 32'hAB000000, 4'b1000);
        run_store(T_STURB, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB, 1);

        // 2: aligned doubleword
        push_beat(64'h2000, 32'h55667788, 4'hF);
        push_beat(64'h2004, 32'h11223344, 4'hF);
        run_store(T_STUR, 64'h2000, 64'h1122334455667788, 2);

        // 3: misaligned doubleword, three beats
        push_beat(64'h2000, 32'h66778800, 4'b1110);
        push_beat(64'h2004, 32'h22334455, 4'hF);
        push_beat(64'h2008, 32'h00000011, 4'b0001);
        run_store(T_STUR, 64'h2001, 64'h1122334455667788, 3);

        // 4: word wrapping past the top of the address space, slow memory
        mode = 2;
        push_beat(64'hFFFF_FFFF_FFFF_FFFC, 32'hBBAA0000, 4'b1100);
        push_beat(64'h0, 32'h0000DDCC, 4'b0011);
        run_store(T_STURW, 64'hFFFF_FFFF_FFFF_FFFE, 64'h12345678_DDCCBBAA, 2);

        // 5: reset during the second beat of a three-beat store
        mode = 0;
        push_beat(64'h2000, 32'h66778800, 4'b1110);
        push_beat(64'h2004, 32'h22334455, 4'hF);
        push_beat(64'h2008, 32'h00000011, 4'b0001);
        @(posedge clk); #1;
        instruction = {T_STUR, 21'd0}; address = 64'h2001; store_data = 64'h1122334455667788;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("after_reset_quiet", {bus.bus_valid, stall, done}, 3'b000);
        push_beat(64'h10, 32'h0000BEEF, 4'b0011);
        run_store(T_STURH, 64'h10, 64'hCAFE_0000_1234_BEEF, 1);

        // 6: non-store opcodes never engage the unit
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            instruction = {(i % 2 == 0) ? T_ADD : T_LDUR, 21'($urandom)};
            address = {$urandom, $urandom};
            start = 1'b1;
            @(negedge clk);
            check("nonstore_quiet", {stall, bus.bus_valid, done}, 3'b000);
        end
        @(posedge clk); #1;
        start = 1'b0;

        // Random stores against the byte-level model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: op = T_STUR;
                1: op = T_STURW;
                2: op = T_STURH;
                default: op = T_STURB;
            endcase
            if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            else a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            mode = $urandom_range(0, 1);
            model_push(size_of(op), a, d, nb);
            run_store(op, a, d, nb);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
